// File: rtl/dmem_pkg.sv
// Shared definitions for the handshaked data memory.
//   state_t     : request FSM states (IDLE, WAIT, RESP)
//   cnt_t       : wait-state counter (holds 0..15)
//   bytes_of    : byte lanes per data word
//   off_w_of    : byte-offset bits inside a word address
//   idx_w_of    : word-index bits
//   addr_bad    : range / alignment check for a byte address
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic int bytes_of(input int width);
    return width / 8;
  endfunction

  function automatic int off_w_of(input int width);
    return $clog2(width / 8);
  endfunction

  function automatic int idx_w_of(input int depth);
    return $clog2(depth);
  endfunction

  // Address arrives zero-extended to 64 bits, so any ADDR_W up to 64 works.
  // Range: any bit above the word index is an error.
  // Alignment: only enforced when check_align is set.
  function automatic logic addr_bad(input logic [63:0] addr,
                                    input int          off_w,
                                    input int          idx_w,
                                    input logic        check_align);
    logic range_err;
    logic align_err;
    range_err = (addr >> (off_w + idx_w)) != 64'd0;
    align_err = check_align && ((addr & ((64'd1 << off_w) - 64'd1)) != 64'd0);
    return range_err || align_err;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x WIDTH synchronous RAM with per-byte-lane write enables and a
// registered read port.
//   clk   : clock
//   we    : per-lane write enables (bit i writes byte lane i)
//   re    : read enable; rdata updates on the next rising edge
//   idx   : word index
//   wdata : write data
//   rdata : registered read data (holds when re=0)
module dmem_array
  import dmem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic                       clk,
  input  logic [WIDTH/8-1:0]         we,
  input  logic                       re,
  input  logic [idx_w_of(DEPTH)-1:0] idx,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; a reset branch would turn the RAM into flops.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH / 8; i++) begin
      if (we[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/data_memory_hs.sv
// Data memory with valid/ready request port, one-cycle response strobe,
// byte-enable stores, WAIT_CYCLES wait states and address checking.
// Optional feature: define DMEM_MISALIGN_CHECK_EN to reject requests whose
// low byte-offset address bits are non-zero; otherwise those bits are ignored.
//   clk, reset          : clock, asynchronous active-high reset
//   req_valid/req_ready : request handshake; accept on valid && ready
//   req_write           : 1 = store, 0 = load
//   req_addr            : byte address
//   req_wdata, req_be   : store data and byte-lane enables
//   rsp_valid           : one-cycle strobe per accepted request
//   rsp_rdata           : load data (0 for stores and errors)
//   rsp_err             : request was out of range or misaligned
module data_memory_hs
  import dmem_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  input  logic [WIDTH/8-1:0] req_be,
  output logic               rsp_valid,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic               rsp_err
);

  localparam int BYTES = bytes_of(WIDTH);
  localparam int OFF_W = off_w_of(WIDTH);
  localparam int IDX_W = idx_w_of(DEPTH);
  // With no wait states the commit edge is the accept edge, so the commit
  // must use the live request rather than the capture registers.
  localparam bit PASS_THRU = (WAIT_CYCLES == 0);

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam logic ALIGN_CHECK = 1'b1;
`else
  localparam logic ALIGN_CHECK = 1'b0;
`endif

  state_t             state, state_d;
  cnt_t               cnt, cnt_d;
  logic               accept, commit;
  logic               write_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [WIDTH-1:0]   wdata_q;
  logic [BYTES-1:0]   be_q;
  logic               c_write, c_err, rd_en, load_ok_q;
  logic [ADDR_W-1:0]  c_addr;
  logic [WIDTH-1:0]   c_wdata, arr_rdata;
  logic [BYTES-1:0]   c_be, we;

  assign req_ready = (state != WAIT);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready && !reset;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    commit  = 1'b0;
    unique case (state)
      IDLE, RESP: begin
        if (!accept) begin
          state_d = IDLE;
        end else if (PASS_THRU) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = cnt_t'(WAIT_CYCLES - 1);
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign c_write = PASS_THRU ? req_write : write_q;
  assign c_addr  = PASS_THRU ? req_addr  : addr_q;
  assign c_wdata = PASS_THRU ? req_wdata : wdata_q;
  assign c_be    = PASS_THRU ? req_be    : be_q;

  assign c_err = addr_bad(64'(c_addr), OFF_W, IDX_W, ALIGN_CHECK);
  assign we    = (commit && c_write && !c_err) ? c_be : '0;
  assign rd_en = commit && !c_write && !c_err;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_err   <= 1'b0;
      load_ok_q <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
      if (commit) begin
        rsp_err   <= c_err;
        load_ok_q <= rd_en;
      end
    end
  end

  // The array's read register only moves on good loads; masking it with the
  // flag registered on the same edge yields 0 for stores, errors and reset.
  assign rsp_rdata = load_ok_q ? arr_rdata : '0;

  dmem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .re    (rd_en),
    .idx   (c_addr[OFF_W +: IDX_W]),
    .wdata (c_wdata),
    .rdata (arr_rdata)
  );

endmodule
